// File: rtl/not_from_nand.sv
// Per-lane inverter built from 2-input NAND primitives, plus a registered copy
// of the inverted value and a saturating counter of sampled input changes.
module not_from_nand #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   output wire logic [WIDTH-1:0] out,
   input  logic [WIDTH-1:0]      in,
   input  logic                  clk,
   input  logic                  rst,
   output logic [WIDTH-1:0]      out_q,
   output logic [CNT_W-1:0]      toggle_cnt,
   output logic                  cnt_sat
);

   logic [WIDTH-1:0] in_prev_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             changed;

   // Tying both NAND inputs together gives an inverter with no clock or reset dependence.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
         nand u_nand (out[gi], in[gi], in[gi]);
      end
   endgenerate

   assign changed = (in != in_prev_q);

   always_comb begin
      cnt_d = cnt_q;
      if (changed && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q     <= '0;
         in_prev_q <= '0;
         cnt_q     <= '0;
      end else begin
         out_q     <= out;
         in_prev_q <= in;
         cnt_q     <= cnt_d;
      end
   end

   assign toggle_cnt = cnt_q;
   assign cnt_sat    = (cnt_q == {CNT_W{1'b1}});

endmodule

// File: tb/tb_not_from_nand.sv
// Directed self-checking bench for not_from_nand: a 4-lane instance with a
// 16-bit counter and a 1-lane instance with a 3-bit counter for saturation.
module tb_not_from_nand;

   logic        clk = 1'b0;
   logic        clk_en = 1'b0;
   logic        rst = 1'b0;

   logic [3:0]  in_a = 4'h0;
   wire  [3:0]  out_a;
   logic [3:0]  out_q_a;
   logic [15:0] cnt_a;
   logic        sat_a;

   logic [0:0]  in_b = 1'b0;
   wire  [0:0]  out_b;
   logic [0:0]  out_q_b;
   logic [2:0]  cnt_b;
   logic        sat_b;

   int n_checks = 0;
   int n_errors = 0;

   not_from_nand #(.WIDTH(4), .CNT_W(16)) dut_a (
      .out(out_a), .in(in_a), .clk(clk), .rst(rst),
      .out_q(out_q_a), .toggle_cnt(cnt_a), .cnt_sat(sat_a)
   );

   not_from_nand #(.WIDTH(1), .CNT_W(3)) dut_b (
      .out(out_b), .in(in_b), .clk(clk), .rst(rst),
      .out_q(out_q_b), .toggle_cnt(cnt_b), .cnt_sat(sat_b)
   );

   // Clock stays low until clk_en is raised.
   always #5 clk = clk_en ? ~clk : 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s got=%0h", tag, got);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] va;
      logic [3:0] exp_a;
      int         eb;

      // Asynchronous reset with the clock held low.
      rst = 1'b1;
      #2;
      chk("rst_out_q", 32'(out_q_a), 32'h0);
      chk("rst_cnt", 32'(cnt_a), 32'h0);
      chk("rst_sat", 32'(sat_a), 32'h0);
      rst = 1'b0;

      // 20 toggles, clock stopped: out follows in, out_q never moves.
      for (int k = 0; k < 20; k++) begin
         va = (k % 2 == 0) ? 4'hF : 4'h0;
         exp_a = (k % 2 == 0) ? 4'h0 : 4'hF;
         in_a = va;
         in_b = 1'((k + 1) % 2);
         #1;
         chk($sformatf("noclk_out_a[%0d]", k), 32'(out_a), 32'(exp_a));
         chk($sformatf("noclk_out_b[%0d]", k), 32'(out_b), 32'((k % 2)));
         chk($sformatf("noclk_out_q[%0d]", k), 32'(out_q_a), 32'h0);
         #4;
      end
      chk("noclk_cnt", 32'(cnt_a), 32'h0);

      // Multi-lane vectors.
      in_a = 4'b1010; #1; chk("vec_1010", 32'(out_a), 32'h5);
      in_a = 4'b0000; #1; chk("vec_0000", 32'(out_a), 32'hF);
      in_a = 4'b0110; #1; chk("vec_0110", 32'(out_a), 32'h9);
      in_a = 4'b1111; #1; chk("vec_1111", 32'(out_a), 32'h0);

      // Clocked: reset held, in=all ones.
      rst = 1'b1;
      in_b = 1'b0;
      clk_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rstclk_out_q", 32'(out_q_a), 32'h0);
      chk("rstclk_cnt", 32'(cnt_a), 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("rel_out_q", 32'(out_q_a), 32'h0);
      chk("rel_cnt_first_edge", 32'(cnt_a), 32'h1);
      in_a = 4'h0;
      @(negedge clk);
      chk("in0_out_q", 32'(out_q_a), 32'hF);
      chk("in0_cnt", 32'(cnt_a), 32'h2);

      // Fresh reset, then 10 toggling cycles on both instances.
      rst = 1'b1;
      #1;
      chk("rerst_cnt", 32'(cnt_a), 32'h0);
      chk("rerst_out_q", 32'(out_q_a), 32'h0);
      in_a = 4'h0;
      in_b = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         in_a = (k % 2 == 0) ? 4'hF : 4'h0;
         in_b = (k % 2 == 0) ? 1'b1 : 1'b0;
         exp_a = (k % 2 == 0) ? 4'h0 : 4'hF;
         @(negedge clk);
         eb = (k + 1 > 7) ? 7 : k + 1;
         chk($sformatf("tog_cnt_a[%0d]", k), 32'(cnt_a), 32'(k + 1));
         chk($sformatf("tog_out_q_a[%0d]", k), 32'(out_q_a), 32'(exp_a));
         chk($sformatf("tog_cnt_b[%0d]", k), 32'(cnt_b), 32'(eb));
         chk($sformatf("tog_sat_b[%0d]", k), 32'(sat_b), (k + 1 >= 7) ? 32'h1 : 32'h0);
      end
      chk("sat_a_low", 32'(sat_a), 32'h0);

      // Hold constant: counters freeze.
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("hold_cnt_a[%0d]", k), 32'(cnt_a), 32'd10);
         chk($sformatf("hold_cnt_b[%0d]", k), 32'(cnt_b), 32'd7);
      end

      // A glitch that returns to the held value before the edge is not counted.
      in_a = 4'h5;
      #2;
      in_a = 4'h0;
      @(negedge clk);
      chk("glitch_cnt", 32'(cnt_a), 32'd10);
      in_a = 4'h1;
      @(negedge clk);
      chk("one_lane_cnt", 32'(cnt_a), 32'd11);

      // Five toggles from reset, ending with in=4'hE so out_q=4'h1.
      rst = 1'b1;
      in_a = 4'h0;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_a = (k == 4) ? 4'hE : ((k % 2 == 0) ? 4'hF : 4'h0);
         @(negedge clk);
      end
      chk("pre_async_cnt", 32'(cnt_a), 32'd5);
      chk("pre_async_out_q", 32'(out_q_a), 32'h1);

      // Asynchronous reset between edges.
      #2;
      rst = 1'b1;
      #1;
      chk("async_cnt_a", 32'(cnt_a), 32'h0);
      chk("async_out_q_a", 32'(out_q_a), 32'h0);
      chk("async_out_a", 32'(out_a), 32'h1);
      chk("async_cnt_b", 32'(cnt_b), 32'h0);
      chk("async_sat_b", 32'(sat_b), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rel_cnt_a", 32'(cnt_a), 32'h1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
